// File: rtl/sine_meter.sv
// Waveform meter for 9-bit offset-binary samples: rising midscale crossings with
// hysteresis give the period in samples, and each completed cycle reports its peaks.
module sine_meter #(
  parameter int HYST     = 8,
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_valid,
  input  logic [8:0]          sample,
  output logic [PERIOD_W-1:0] period,
  output logic [8:0]          vmax,
  output logic [8:0]          vmin,
  output logic [8:0]          vpp,
  output logic                meas_valid,
  output logic                locked
);

  typedef enum logic [1:0] {
    SEEK_LOW,
    SEEK_HIGH,
    MEAS_HIGH,
    MEAS_LOW
  } state_t;

  localparam logic [8:0] LOW_TH  = 9'(256 - HYST);
  localparam logic [8:0] HIGH_TH = 9'(256 + HYST);
  // Largest count that can still be reported as cnt+1 without wrapping.
  localparam logic [PERIOD_W-1:0] CNT_LIMIT = {{(PERIOD_W-1){1'b1}}, 1'b0};

  state_t state, next_state;

  logic [PERIOD_W-1:0] cnt;
  logic [8:0]          run_max;
  logic [8:0]          run_min;

  logic is_low;
  logic is_high;
  logic at_limit;
  logic crossing;
  logic complete;
  logic accumulate;
  logic timeout;

  always_ff @(posedge clk) begin
    if (rst) state <= SEEK_LOW;
    else     state <= next_state;
  end

  always_comb begin
    is_low     = (sample < LOW_TH);
    is_high    = (sample >= HIGH_TH);
    at_limit   = (cnt == CNT_LIMIT);
    next_state = state;
    if (sample_valid) begin
      case (state)
        SEEK_LOW:  if (is_low)  next_state = SEEK_HIGH;
        SEEK_HIGH: if (is_high) next_state = MEAS_HIGH;
        MEAS_HIGH: begin
          if (at_limit)    next_state = SEEK_LOW;
          else if (is_low) next_state = MEAS_LOW;
        end
        MEAS_LOW: begin
          if (is_high)       next_state = MEAS_HIGH;
          else if (at_limit) next_state = SEEK_LOW;
        end
        default: next_state = SEEK_LOW;
      endcase
    end
  end

  // The crossing sample opens the new cycle; every other accepted sample while
  // measuring is accumulated into the cycle in progress.
  always_comb begin
    crossing   = 1'b0;
    complete   = 1'b0;
    accumulate = 1'b0;
    timeout    = 1'b0;
    if (sample_valid) begin
      crossing   = is_high && ((state == SEEK_HIGH) || (state == MEAS_LOW));
      complete   = is_high && (state == MEAS_LOW);
      accumulate = (state == MEAS_HIGH) || ((state == MEAS_LOW) && !is_high);
      timeout    = accumulate && at_limit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      run_max    <= 9'd0;
      run_min    <= 9'd511;
      period     <= '0;
      vmax       <= 9'd0;
      vmin       <= 9'd0;
      vpp        <= 9'd0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
    end else begin
      meas_valid <= complete;
      if (complete) begin
        period <= cnt + 1'b1;
        vmax   <= run_max;
        vmin   <= run_min;
        vpp    <= run_max - run_min;
      end
      if (crossing) begin
        cnt     <= '0;
        run_max <= sample;
        run_min <= sample;
        locked  <= 1'b1;
      end else if (timeout) begin
        cnt    <= '0;
        locked <= 1'b0;
      end else if (accumulate) begin
        cnt <= cnt + 1'b1;
        if (sample > run_max) run_max <= sample;
        if (sample < run_min) run_min <= sample;
      end
    end
  end

endmodule

// File: tb/tb_sine_meter.sv
// Directed bench for sine_meter: expected measurements are queued when the
// completing crossing sample is driven and matched against meas_valid pulses.
module tb_sine_meter;

  logic       clk = 1'b0;
  logic       rst;
  logic       sample_valid;
  logic       valid8;
  logic [8:0] sample;

  logic [15:0] period;
  logic [8:0]  vmax, vmin, vpp;
  logic        meas_valid, locked;

  logic [7:0]  period8;
  logic [8:0]  vmax8, vmin8, vpp8;
  logic        meas_valid8, locked8;

  typedef struct {
    int due;
    int period;
    int vmax;
    int vmin;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  bit   route8 = 1'b0;
  bit   mon_en = 1'b0;
  int   sine_tbl[512];
  int   xi = 0;

  sine_meter #(.HYST(8), .PERIOD_W(16)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample(sample),
    .period(period), .vmax(vmax), .vmin(vmin), .vpp(vpp),
    .meas_valid(meas_valid), .locked(locked)
  );

  sine_meter #(.HYST(8), .PERIOD_W(8)) dut8 (
    .clk(clk), .rst(rst), .sample_valid(valid8), .sample(sample),
    .period(period8), .vmax(vmax8), .vmin(vmin8), .vpp(vpp8),
    .meas_valid(meas_valid8), .locked(locked8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drives one sample on the falling edge; it is accepted on the next rising edge.
  task automatic applyStimulus(input logic v, input logic [8:0] s, input bit push = 1'b0,
                               input int p = 0, input int mx = 0, input int mn = 0);
    exp_t e;
    @(negedge clk);
    sample       = s;
    sample_valid = v && !route8;
    valid8       = v && route8;
    if (push) begin
      e.due    = cyc + 1;
      e.period = p;
      e.vmax   = mx;
      e.vmin   = mn;
      q.push_back(e);
    end
  endtask

  task automatic applyReset(input logic v);
    @(negedge clk);
    rst          = 1'b1;
    sample       = 9'd320;
    sample_valid = v && !route8;
    valid8       = v && route8;
    @(negedge clk);
    rst          = 1'b0;
    sample_valid = 1'b0;
    valid8       = 1'b0;
  endtask

  task automatic sendSquare(input logic [8:0] s, input bit push, input int gap);
    applyStimulus(1'b1, s, push, 20, 320, 200);
    for (int g = 0; g < gap; g++) applyStimulus(1'b0, 9'($urandom_range(0, 511)));
  endtask

  // Cycles of 10 low then 10 high; crossings from index first_done onward complete a cycle.
  task automatic driveSquare(input int ncyc, input int gap, input int first_done);
    for (int c = 0; c < ncyc; c++) begin
      for (int k = 0; k < 10; k++) sendSquare(9'd200, 1'b0, gap);
      for (int k = 0; k < 10; k++) sendSquare(9'd320, (k == 0) && (c >= first_done), gap);
    end
  endtask

  task automatic checkCleared(input string tag);
    checkOutput({tag, "_period"}, 32'(period), 0);
    checkOutput({tag, "_vmax"}, 32'(vmax), 0);
    checkOutput({tag, "_vmin"}, 32'(vmin), 0);
    checkOutput({tag, "_vpp"}, 32'(vpp), 0);
    checkOutput({tag, "_locked"}, 32'(locked), 0);
    checkOutput({tag, "_meas_valid"}, 32'(meas_valid), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit   due_now;
    if (mon_en) begin
      due_now = (q.size() > 0) && (q[0].due == cyc);
      checkOutput("meas_valid", 32'(meas_valid), 32'(due_now));
      if (due_now) begin
        e = q.pop_front();
        checkOutput("period", 32'(period), e.period);
        checkOutput("vmax", 32'(vmax), e.vmax);
        checkOutput("vmin", 32'(vmin), e.vmin);
        checkOutput("vpp", 32'(vpp), e.vmax - e.vmin);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    sample_valid = 1'b0;
    valid8       = 1'b0;
    sample       = 9'd0;
    for (int i = 0; i < 512; i++)
      sine_tbl[i] = $rtoi(256.0 + 255.0 * $sin(2.0 * 3.14159265358979 * i / 512.0) + 0.5);
    for (int i = 1; i < 256; i++)
      if (sine_tbl[i] >= 264 && sine_tbl[i-1] < 264) xi = i;

    applyReset(1'b0);
    mon_en = 1'b1;
    checkCleared("reset");
    checkOutput("reset_locked8", 32'(locked8), 0);

    // In-band oscillation must never lock
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 9'(250 + (i % 13)));
    applyStimulus(1'b0, 9'd256);
    checkCleared("band");

    // Generator loopback, 512 samples per cycle
    applyReset(1'b0);
    for (int p = 0; p < 4; p++)
      for (int i = 0; i < 512; i++)
        applyStimulus(1'b1, 9'(sine_tbl[i]), (p >= 2) && (i == xi), 512, 511, 1);
    applyStimulus(1'b0, 9'd0);
    checkOutput("sine_locked", 32'(locked), 1);
    checkOutput("sine_vpp", 32'(vpp), 510);
    checkOutput("sine_pending", 32'(q.size()), 0);

    // Continuous square wave
    applyReset(1'b0);
    driveSquare(4, 0, 1);
    applyStimulus(1'b0, 9'd0);
    checkOutput("sq_locked", 32'(locked), 1);
    checkOutput("sq_period", 32'(period), 20);
    checkOutput("sq_pending", 32'(q.size()), 0);

    // Valid on every third cycle only
    applyReset(1'b0);
    driveSquare(3, 2, 1);
    applyStimulus(1'b0, 9'd0);
    checkOutput("gap_locked", 32'(locked), 1);
    checkOutput("gap_period", 32'(period), 20);
    checkOutput("gap_pending", 32'(q.size()), 0);

    // Reset in the middle of a locked cycle
    applyReset(1'b0);
    driveSquare(2, 0, 1);
    for (int k = 0; k < 10; k++) sendSquare(9'd200, 1'b0, 0);
    sendSquare(9'd320, 1'b1, 0);
    for (int k = 0; k < 4; k++) sendSquare(9'd320, 1'b0, 0);
    applyReset(1'b1);
    checkCleared("midrst");
    for (int k = 0; k < 5; k++) sendSquare(9'd320, 1'b0, 0);
    applyStimulus(1'b0, 9'd0);
    checkOutput("midrst_still_unlocked", 32'(locked), 0);
    driveSquare(3, 0, 1);
    applyStimulus(1'b0, 9'd0);
    checkOutput("midrst_period", 32'(period), 20);
    checkOutput("midrst_locked", 32'(locked), 1);
    checkOutput("midrst_pending", 32'(q.size()), 0);

    // Timeout with an 8-bit counter: lock, then hold a high level
    route8 = 1'b1;
    applyReset(1'b0);
    driveSquare(1, 0, 1);
    for (int k = 0; k < 10; k++) applyStimulus(1'b1, 9'd200);
    applyStimulus(1'b1, 9'd320);
    applyStimulus(1'b1, 9'd320);
    checkOutput("to_meas_pulse", 32'(meas_valid8), 1);
    applyStimulus(1'b1, 9'd320);
    checkOutput("to_meas_single", 32'(meas_valid8), 0);
    checkOutput("to_period_lock", 32'(period8), 20);
    for (int k = 0; k < 252; k++) applyStimulus(1'b1, 9'd300);
    applyStimulus(1'b0, 9'd300);
    checkOutput("to_locked_before", 32'(locked8), 1);
    applyStimulus(1'b1, 9'd300);
    applyStimulus(1'b0, 9'd300);
    checkOutput("to_locked_after", 32'(locked8), 0);
    checkOutput("to_meas_valid", 32'(meas_valid8), 0);
    checkOutput("to_period_hold", 32'(period8), 20);
    checkOutput("to_vmax_hold", 32'(vmax8), 320);
    checkOutput("to_vmin_hold", 32'(vmin8), 200);
    checkOutput("to_vpp_hold", 32'(vpp8), 120);
    applyStimulus(1'b1, 9'd320);
    applyStimulus(1'b0, 9'd320);
    checkOutput("to_seek_low_ignores_high", 32'(locked8), 0);
    applyStimulus(1'b1, 9'd200);
    applyStimulus(1'b1, 9'd320);
    applyStimulus(1'b0, 9'd320);
    checkOutput("to_relock", 32'(locked8), 1);
    route8 = 1'b0;

    applyStimulus(1'b0, 9'd0);
    checkOutput("final_pending", 32'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sine_meter.md
# sine_meter

Waveform measurement block that consumes a stream of 9-bit offset-binary samples, with midscale 256 and range 0..511, the same format produced by the sine generator. It detects rising midscale crossings with hysteresis, counts samples per cycle, and tracks per-cycle peak values. It sits between a sample source (generator loopback or ADC front end) and the display/readout logic, and provides one measurement per full input cycle.

## Interface
- HYST, 8: hysteresis half-width around midscale. High threshold is 256+HYST, low threshold is 256-HYST. Legal range 1..127.
- PERIOD_W, 16: width of the sample counter and of `period`.

- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- sample_valid  in  1  qualifies `sample` for one cycle.
- sample  in  9  offset-binary sample.
- period  out  PERIOD_W  samples per cycle of the last completed measurement.
- vmax  out  9  maximum sample in the last completed cycle.
- vmin  out  9  minimum sample in the last completed cycle.
- vpp  out  9  vmax − vmin.
- meas_valid  out  1  one-cycle pulse when period/vmax/vmin/vpp update.
- locked  out  1  high while at least one rising crossing has been seen and no timeout has occurred since.

## Operation
- Only cycles with sample_valid=1 advance the block. When sample_valid=0, all state and outputs hold, and meas_valid is 0.
- A sample is "low" if sample < 256−HYST and "high" if sample ≥ 256+HYST. Any other sample is in band and causes no state change.
- A rising crossing is the first high sample accepted while in SEEK_HIGH or MEAS_LOW.
- States and transitions:
  - SEEK_LOW: on a low sample → SEEK_HIGH.
  - SEEK_HIGH: on a high sample, this is the first crossing → MEAS_HIGH. Set cnt=0, and set run_max = run_min = sample. Set locked=1. No meas_valid.
  - MEAS_HIGH: on a low sample → MEAS_LOW.
  - MEAS_LOW: on a high sample, the cycle is complete. Register period=cnt+1, vmax=run_max, vmin=run_min, vpp=run_max−run_min. Pulse meas_valid. Then restart: cnt=0, run_max = run_min = sample, next state MEAS_HIGH.
- Accumulation in MEAS_HIGH and MEAS_LOW: every accepted non-crossing sample increments cnt and updates run_max and run_min. The crossing sample belongs to the new cycle, not the completed one.
- Timeout: in MEAS_HIGH or MEAS_LOW, if an accepted non-crossing sample arrives while cnt = 2^PERIOD_W − 2:
  - go to SEEK_LOW and clear locked;
  - do not pulse meas_valid;
  - period, vmax, vmin and vpp hold their last values.
- Arithmetic is unsigned. vpp cannot underflow because run_max ≥ run_min always holds.
- Reset has priority over all other activity:
  - state = SEEK_LOW, cnt = 0;
  - run_max = 0, run_min = 511;
  - all outputs = 0.
- Reset mid-measurement discards the partial cycle.

## Timing
- All outputs are registered.
- On the clk edge that accepts the completing crossing sample, period, vmax, vmin and vpp update and meas_valid goes high. meas_valid is visible for exactly the following cycle, which is a latency of 1 cycle from sample acceptance.
- locked rises on the edge that accepts the first crossing sample, and falls on the timeout edge or on rst.
- Back-to-back valid samples are accepted every cycle, and there are no stall conditions.
- The minimum reportable period is 2: one high sample followed by one low sample, then a high sample.

## Test plan
- Generator loopback, 512 samples per cycle, peaks 511/1, sample_valid=1 continuously:
  - first meas_valid arrives one cycle after the second rising crossing;
  - period=512, vmax=511, vmin=1, vpp=510;
  - meas_valid then repeats every 512 cycles with identical values.
- Square wave alternating 10×200 and 10×320, HYST=8 → period=20, vmax=320, vmin=200, vpp=120, locked=1.
- Same square wave with sample_valid=1 only on every third cycle → same period=20 (gaps do not count), and meas_valid spacing is 60 cycles.
- Samples oscillating 250..262 with HYST=8 → no crossing detected, locked=0, meas_valid never asserted, outputs stay 0.
- With PERIOD_W=8, lock on the square wave, then hold sample at 300:
  - after 253 further accepted samples, locked drops to 0 and the state is SEEK_LOW;
  - period=20 and the peak outputs hold.
- rst asserted for one cycle mid-cycle after lock:
  - next cycle all outputs are 0 and locked=0;
  - the next meas_valid arrives only after two new rising crossings, with a correct period.
